// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Owner of the read data returning on the cycle after a grant. Doubles as the FSM state:
  // TAG_NONE = IDLE, TAG_FETCH = RD_F, TAG_DATA = RD_D.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_e;

  // Every access is a single word.
  localparam logic [1:0] ACC_WORD = 2'b00;

  // Starve counter width; large enough for limits up to 15.
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_prio_select.sv
// Combinational priority select between fetch and data for the shared memory port.
module arb_prio_select (
  input  logic i_f_req,
  input  logic i_d_req,
  input  logic i_d_misaligned,
  input  logic i_starve_hit,
  input  logic i_busy,
  output logic o_grant_f,
  output logic o_grant_d,
  output logic o_err
);

  // Data normally wins; a starved fetch wins outright; a misaligned data request is
  // rejected without using the port, so fetch may take the slot in the same cycle.
  always_comb begin
    o_grant_f = 1'b0;
    o_grant_d = 1'b0;
    o_err     = 1'b0;
    if (!i_busy) begin
      if (i_f_req && i_starve_hit) begin
        o_grant_f = 1'b1;
      end else if (i_d_req) begin
        o_grant_d = 1'b1;
        o_err     = i_d_misaligned;
        o_grant_f = i_f_req & i_d_misaligned;
      end else begin
        o_grant_f = i_f_req;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one mainMem port between fetch (instruction reads) and the memory stage (loads
// and stores). Reads return one cycle after grant; a 1-entry tag routes the returning word.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              fetch_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_err,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [1:0]        mem_acc_size,
  output logic              mem_wren,
  output logic              mem_enable,
  input  logic              mem_busy
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  tag_e                r_tag;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [DATA_W-1:0]   r_f_hold;
  logic [DATA_W-1:0]   r_d_hold;

  logic w_hold_off;
  logic w_misaligned;
  logic w_starve_hit;
  logic w_grant_f;
  logic w_grant_d;
  logic w_err;
  logic w_issue_d;
  logic w_store;

  // Reset is folded into the arbiter's hold-off so every grant output is 0 while in reset.
  assign w_hold_off   = mem_busy | reset;
  // Word-offset bits are the two LSBs.
  assign w_misaligned = |d_addr[1:0];
  assign w_starve_hit = (r_starve_cnt == STARVE_MAX);

  arb_prio_select u_prio (
    .i_f_req        (f_req),
    .i_d_req        (d_req),
    .i_d_misaligned (w_misaligned),
    .i_starve_hit   (w_starve_hit),
    .i_busy         (w_hold_off),
    .o_grant_f      (w_grant_f),
    .o_grant_d      (w_grant_d),
    .o_err          (w_err)
  );

  assign w_issue_d = w_grant_d & ~w_err;
  assign w_store   = w_issue_d & d_we;

  // Grant side: combinational drive of the memory port from the winning requester.
  always_comb begin
    f_gnt        = w_grant_f;
    d_gnt        = w_grant_d;
    d_err        = w_err;
    fetch_stall  = f_req & ~w_grant_f & ~reset;
    mem_enable   = w_grant_f | w_issue_d;
    mem_wren     = w_store;
    mem_acc_size = ACC_WORD;
    mem_addr     = '0;
    mem_data_in  = '0;
    if (w_issue_d) begin
      mem_addr = d_addr;
    end else if (w_grant_f) begin
      mem_addr = f_addr;
    end
    if (w_store) begin
      mem_data_in = d_wdata;
    end
  end

  // Return side: the tag register marks the cycle in which mem_data_out belongs to a requester.
  always_comb begin
    f_valid = (r_tag == TAG_FETCH);
    d_valid = (r_tag == TAG_DATA);
    f_rdata = f_valid ? mem_data_out : r_f_hold;
    d_rdata = d_valid ? mem_data_out : r_d_hold;
  end

  // Return-tag FSM, starve counter and rdata hold registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tag        <= TAG_NONE;
      r_starve_cnt <= '0;
      r_f_hold     <= '0;
      r_d_hold     <= '0;
    end else begin
      if (r_tag == TAG_FETCH) r_f_hold <= mem_data_out;
      if (r_tag == TAG_DATA)  r_d_hold <= mem_data_out;

      if (w_grant_f) begin
        r_tag <= TAG_FETCH;
      end else if (w_issue_d && !d_we) begin
        r_tag <= TAG_DATA;
      end else begin
        r_tag <= TAG_NONE;
      end

      // Counter only moves on cycles where an issue decision is made.
      if (!mem_busy) begin
        if (w_grant_f || !f_req) begin
          r_starve_cnt <= '0;
        end else if (w_grant_d && (r_starve_cnt != STARVE_MAX)) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single mainMem port between two requesters: the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Sequences memory accesses, routes returning read data to the requester that owns it, and generates the fetch stall.
- Sits between the fetch/memory pipeline stages and mainMem. It replaces the direct addr/wren/acc_size drive from the top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting before fetch is forced a grant (range 1..15).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- f_req  in  1  fetch read request; held until f_gnt
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_valid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetched instruction
- fetch_stall  out  1  equals f_req & ~f_gnt; drives fetch stall
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted (or rejected) this cycle
- d_err  out  1  pulses with d_gnt on a misaligned request
- d_valid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  to mainMem addr
- mem_data_in  out  DATA_W  to mainMem data_in
- mem_data_out  in  DATA_W  from mainMem data_out
- mem_acc_size  out  2  always 2'b00 (single word)
- mem_wren  out  1  to mainMem wren
- mem_enable  out  1  to mainMem enable
- mem_busy  in  1  from mainMem busy

Behaviour:
- Bit numbering is [0:N-1], MSB at index 0. The word-offset bits are addr[30:31].
- Reset (async, active-high) values:
  - All outputs 0, except mem_acc_size = 2'b00.
  - Return tag = NONE, starve counter = 0, state = IDLE.
- Issue decision is made each cycle in which mem_busy = 0. No issue occurs while mem_busy = 1; gnts stay 0 and requests wait.
- Priority:
  - d_req wins over f_req.
  - Exception: when starve_cnt == STARVE_LIMIT and f_req = 1, fetch wins.
- Starve counter:
  - Increments when data is granted while f_req = 1.
  - Clears on any fetch grant or when f_req = 0.
  - Saturates at STARVE_LIMIT.
- Misaligned data request (d_addr[30:31] != 0):
  - d_gnt = 1 and d_err = 1 in the same cycle.
  - Nothing is issued to memory. The slot is free for fetch in that cycle.
  - Fetch requests are never checked for alignment.
- Issue cycle: gnt = 1 (combinational) and mem_enable = 1. mem_addr, mem_wren and mem_data_in are driven combinationally from the winning requester.
- Stores complete at grant. There is no return.
- Loads and fetches return read data one cycle after grant:
  - f_valid or d_valid = 1 for exactly one cycle.
  - rdata = mem_data_out in that cycle.
  - Owner is taken from a 1-cycle return tag register (NONE/FETCH/DATA) written at grant.
- Pipelined: a new request may be granted in the same cycle a previous read returns. Sustained throughput is one access per cycle.
- State machine:
  - IDLE (tag NONE) -> RD_F on fetch grant, RD_D on load grant; stays IDLE on store, error or no grant.
  - RD_F / RD_D: deliver return, then transition per that cycle's issue decision.
- mem_busy asserting in RD_F/RD_D does not delay the return. Data for an already-issued read is delivered.
- rdata outputs hold their last value when valid = 0.
- Reset mid-read: the pending return is dropped and no valid pulse is produced after reset deasserts.
- Simultaneous f_req and d_req with mem_busy = 1: both wait; the starve counter is unchanged.

Decomposition:
- Shared package (control.vh style include): the return-tag encoding (TAG_NONE = 2'd0, TAG_FETCH = 2'd1, TAG_DATA = 2'd2) and the ACC_WORD = 2'b00 constant.
- One natural sub-module: arb_prio_select. It is combinational and takes f_req, d_req, d_misaligned, starve_hit and busy. It produces grant_f, grant_d and err.
- Sequential logic (tag, starve counter, valid pulses) stays in the top module.

Test Plan:
- Fetch only:
  - Stimulus: f_req held with f_addr = 0x80020000, then 0x80020004, 0x80020008; memory preloaded with 0x20010005, 0x20020007, 0x00221820.
  - Required: f_gnt every cycle; f_valid on cycles 2-4 with those words in order; fetch_stall = 0 throughout.
- Simultaneous requests:
  - Stimulus: f_req and d_req (load, 0x80020100) asserted together.
  - Required: d_gnt first, f_gnt next cycle, fetch_stall = 1 for exactly 1 cycle; d_valid then f_valid on consecutive cycles.
- Starvation guard:
  - Stimulus: STARVE_LIMIT = 4, d_req and f_req held continuously.
  - Required: grant pattern D,D,D,D,F repeating.
- Store then load same address:
  - Stimulus: store 0xDEADBEEF to 0x80020200, then load 0x80020200.
  - Required: mem_wren = 1 only in the store grant cycle; d_rdata = 0xDEADBEEF one cycle after the load grant.
- Misaligned and busy:
  - Stimulus: load at 0x80020202.
  - Required: d_gnt = d_err = 1, mem_enable = 0.
  - Stimulus: then mem_busy = 1 for 3 cycles with f_req = 1.
  - Required: no gnt for 3 cycles, f_gnt in cycle 4.
- Reset mid-read:
  - Stimulus: assert reset asynchronously in the cycle after a fetch grant.
  - Required: f_valid never pulses; all outputs 0 immediately; normal fetch resumes after release.
